flex_counter_ud: RTL
====================

# flex_counter_ud

Parametrised up/down successor to the 16-bit flex counter wrapper. Counts over a programmable range 1..`rollover_val` in either direction, with synchronous clear, parallel load and a per-instance wrap or saturate mode. Emits registered terminal flags and a one-cycle carry pulse so instances can be cascaded. It serves as the general-purpose counter for timers, bit/byte counters and baud dividers in the datapath.

## Interface
- `NUM_CNT_BITS`, 4: counter width N (2..32).
- `SATURATE`, 0: 0 = wrap at range ends; 1 = hold at range ends.
- `clk` input 1: single clock, rising edge.
- `n_rst` input 1: reset, asynchronous, active-low.
- `clear` input 1: synchronous clear to 0.
- `load_enable` input 1: synchronous parallel load.
- `load_val` input N: value loaded when `load_enable`=1.
- `count_enable` input 1: advance one step this cycle.
- `count_up` input 1: step direction, 1 = up, 0 = down (sampled only on enabled steps).
- `rollover_val` input N: top of range R; may change at any time.
- `count_out` output N: current count.
- `rollover_flag` output 1: registered; 1 iff `count_out` == R and R != 0.
- `underflow_flag` output 1: registered; 1 iff `count_out` == 1, R != 0, and the last enabled step was down.
- `carry_out` output 1: registered one-cycle pulse, asserted the cycle after a wrap.

## Operation
- Per-edge priority: `n_rst` > `clear` > `load_enable` > `count_enable` > hold.
- `clear`: `count_out`=0, internal `dir_q`=up, all flags 0.
- Load: `count_out`=`load_val`, with no clamping. `dir_q` is unchanged and `carry_out` is 0.
- Value 0 is the idle start value. The first enabled step from 0 goes to 1 when up and to R when down, in either mode.
- Up step at c, R != 0:
  - c < R: c+1.
  - c >= R, SATURATE=0: wrap to 1 and set `carry_out` next cycle.
  - c >= R, SATURATE=1: clamp to R.
- Down step at c, R != 0:
  - 1 < c <= R: c-1.
  - c == 1, SATURATE=0: wrap to R and set `carry_out`.
  - c == 1, SATURATE=1: hold at 1.
  - c > R (for example after R is lowered or an out-of-range load): go to R with no carry.
- R == 0: `count_out` is forced to 0 on any enabled step. All flags and `carry_out` stay 0.
- `dir_q` takes the value of `count_up` on every enabled step. It gates `underflow_flag` only.
- Flags are computed from the next count value and the next `dir_q`, then registered, so they align with `count_out` (no extra cycle of lag).
- Arithmetic is N bits, unsigned. c+1 never overflows because wrap is decided by the compare first. With R = 2^N−1 the full range is used.

## Timing
- Reset: `count_out`=0, `rollover_flag`=0, `underflow_flag`=0, `carry_out`=0, `dir_q`=up. Reset takes effect immediately and asynchronously, including mid-count.
- Latency is one cycle from the enabled edge to the new `count_out` and flags.
- `carry_out` is high for exactly one cycle per wrap. It is high in the same cycle `count_out` shows the wrapped value (1 for up, R for down).
- Back-to-back wraps (R=1, up, enable held) keep `carry_out` high every cycle.
- `clear` or load in the same cycle as a would-be wrap: no carry, because the higher-priority action wins.
- With `count_enable`=0, all state holds. Flags re-evaluate only on clear, load or step, except that R changing while holding does not update flags until the next update edge.

## Structure
- Package `flex_counter_pkg`:
  - `typedef enum logic {DIR_DOWN=1'b0, DIR_UP=1'b1} cnt_dir_t`.
  - Mode constants `MODE_WRAP=0` and `MODE_SAT=1`.
- Sub-module `flex_counter_step`: purely combinational. Parameters N and SATURATE. Inputs c, R, dir. Outputs next c and wrap. This keeps the top block as registers plus priority mux.
- `flex_counter16` is re-pointable to `flex_counter_ud #(16,0)` with `count_up` tied to 1 and load tied off.

## Test plan
1. N=4, wrap, R=5, up, enable held from 0 → `count_out` 1,2,3,4,5,1,2. `rollover_flag` is high at 5. `carry_out` is high only in the cycle showing the 1 after 5.
2. Down, R=5, from 0 → 5,4,3,2,1,5. `underflow_flag` is high at 1. `carry_out` pulses once, on the return to 5.
3. SATURATE=1, R=5, up for 8 steps → holds at 5 with `rollover_flag` steady high and `carry_out` never high. Then down for 6 steps → holds at 1.
4. `clear`, `load_enable` (`load_val`=9) and `count_enable` asserted together → `count_out`=0. Next cycle: load 9 alone with R=5 → 9, no flags. Up step → 1 with `carry_out`=1.
5. Count at 7 with R=12, then R changed to 4 → up step gives 1 with carry, while a down step instead gives 4 with no carry. Separately, R=0 with enable held → stays 0 with all flags 0.
6. Count at 3 mid-sequence, `n_rst` pulsed low between clock edges → outputs go to 0 immediately. After release, the first up step gives 1.

Source files
------------

// File: rtl/flex_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : flex_counter_pkg
//  Brief    : Shared direction type and wrap/saturate mode constants for the
//             up/down flex counter.
//  Revision : 1.0
// ============================================================================
package flex_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } cnt_dir_t;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage
`default_nettype wire

// File: rtl/flex_counter_step.sv
`default_nettype none
// ============================================================================
//  Module   : flex_counter_step
//  Brief    : Combinational next-count and wrap computation for one step of
//             the up/down flex counter over the range 1..rollover.
//  Revision : 1.0
// ============================================================================
module flex_counter_step
  import flex_counter_pkg::*;
#(
  parameter int N        = 4,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [N-1:0] i_cnt,
  input  logic [N-1:0] i_rollover,
  input  cnt_dir_t     i_dir,
  output logic [N-1:0] o_cnt_next,
  output logic         o_wrap
);

  localparam logic [N-1:0] c_one = N'(1);

  always_comb begin
    o_cnt_next = i_cnt;
    o_wrap     = 1'b0;
    if (i_rollover == '0) begin
      o_cnt_next = '0;
    end else if (i_cnt == '0) begin
      // Idle start value enters the range at the near end for the direction.
      o_cnt_next = (i_dir == DIR_UP) ? c_one : i_rollover;
    end else if (i_dir == DIR_UP) begin
      if (i_cnt < i_rollover) begin
        o_cnt_next = i_cnt + c_one;
      end else if (SATURATE == MODE_SAT) begin
        o_cnt_next = i_rollover;
      end else begin
        o_cnt_next = c_one;
        o_wrap     = 1'b1;
      end
    end else begin
      if (i_cnt > i_rollover) begin
        // Above range (lowered rollover or wide load): re-enter without carry.
        o_cnt_next = i_rollover;
      end else if (i_cnt == c_one) begin
        if (SATURATE == MODE_SAT) begin
          o_cnt_next = c_one;
        end else begin
          o_cnt_next = i_rollover;
          o_wrap     = 1'b1;
        end
      end else begin
        o_cnt_next = i_cnt - c_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/flex_counter_ud.sv
`default_nettype none
// ============================================================================
//  Module   : flex_counter_ud
//  Brief    : Parametrised up/down counter with clear, load, wrap/saturate
//             mode, registered terminal flags and a cascade carry pulse.
//  Revision : 1.0
// ============================================================================
module flex_counter_ud
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4,
  parameter int SATURATE     = MODE_WRAP
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load_enable,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    count_up,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    underflow_flag,
  output logic                    carry_out
);

  localparam logic [NUM_CNT_BITS-1:0] c_one = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] r_count;
  cnt_dir_t                r_dir;
  logic                    r_rollover;
  logic                    r_underflow;
  logic                    r_carry;

  logic [NUM_CNT_BITS-1:0] w_step_cnt;
  logic                    w_step_wrap;
  cnt_dir_t                w_step_dir;

  logic [NUM_CNT_BITS-1:0] w_cnt_nxt;
  cnt_dir_t                w_dir_nxt;
  logic                    w_carry_nxt;
  logic                    w_update;
  logic                    w_rollover_nxt;
  logic                    w_underflow_nxt;

  assign w_step_dir = cnt_dir_t'(count_up);

  flex_counter_step #(
    .N        (NUM_CNT_BITS),
    .SATURATE (SATURATE)
  ) u_step (
    .i_cnt      (r_count),
    .i_rollover (rollover_val),
    .i_dir      (w_step_dir),
    .o_cnt_next (w_step_cnt),
    .o_wrap     (w_step_wrap)
  );

  always_comb begin
    w_cnt_nxt   = r_count;
    w_dir_nxt   = r_dir;
    w_carry_nxt = 1'b0;
    w_update    = 1'b0;
    if (clear) begin
      w_cnt_nxt = '0;
      w_dir_nxt = DIR_UP;
      w_update  = 1'b1;
    end else if (load_enable) begin
      w_cnt_nxt = load_val;
      w_update  = 1'b1;
    end else if (count_enable) begin
      w_cnt_nxt   = w_step_cnt;
      w_dir_nxt   = w_step_dir;
      w_carry_nxt = w_step_wrap;
      w_update    = 1'b1;
    end
  end

  // Flags look at the post-edge count so they line up with count_out.
  assign w_rollover_nxt  = (w_cnt_nxt == rollover_val) && (rollover_val != '0);
  assign w_underflow_nxt = (w_cnt_nxt == c_one) && (rollover_val != '0) &&
                           (w_dir_nxt == DIR_DOWN);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count     <= '0;
      r_dir       <= DIR_UP;
      r_rollover  <= 1'b0;
      r_underflow <= 1'b0;
      r_carry     <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_carry <= w_carry_nxt;
      if (w_update) begin
        r_rollover  <= w_rollover_nxt;
        r_underflow <= w_underflow_nxt;
      end
    end
  end

  assign count_out      = r_count;
  assign rollover_flag  = r_rollover;
  assign underflow_flag = r_underflow;
  assign carry_out      = r_carry;

endmodule
`default_nettype wire
